// File: rtl/mark_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mark_pkg
// Description : Shared types and constants for the Golomb ruler result
//               read-out path (mark width, count width, stream FSM states,
//               result-slot width helper).
// Revision    : 1.0 - initial release
// ============================================================================
package mark_pkg;

  localparam int MARKWIDTH = 9;
  localparam int CNTWIDTH  = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_MARKS   = 2'd2,
    ST_TRAILER = 2'd3
  } state_t;

  // Width of one stored solution: every mark including mark 0.
  function automatic int slot_width(input int num_positions);
    return (num_positions + 1) * MARKWIDTH;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mark_word_select.sv
`default_nettype none
// ============================================================================
// Module      : mark_word_select
// Description : Combinational indexer returning mark mi of result ri from a
//               packed results vector. Result 1 sits in the MSBs and mark 0
//               sits in the MSBs of each result. ri is 1-based; an index pair
//               outside the stored range returns zero.
// Revision    : 1.0 - initial release
// ============================================================================
module mark_word_select
  import mark_pkg::*;
#(
  parameter int NUMPOSITIONS = 5,
  parameter int NUMRESULTS   = 10
) (
  input  logic [slot_width(NUMPOSITIONS)*NUMRESULTS-1:0] vec,
  input  logic [CNTWIDTH-1:0]                            ri,
  input  logic [CNTWIDTH-1:0]                            mi,
  output logic [MARKWIDTH-1:0]                           word
);

  localparam int SLOT  = slot_width(NUMPOSITIONS);
  localparam int TOTAL = SLOT * NUMRESULTS;

  // Fully decoded mux over every (result, mark) position, MSB-first packing.
  always_comb begin
    word = '0;
    for (int r = 0; r < NUMRESULTS; r++) begin
      for (int m = 0; m <= NUMPOSITIONS; m++) begin
        if (ri == CNTWIDTH'(r + 1) && mi == CNTWIDTH'(m)) begin
          word = vec[TOTAL - 1 - r*SLOT - m*MARKWIDTH -: MARKWIDTH];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mark_result_streamer.sv
`default_nettype none
// ============================================================================
// Module      : mark_result_streamer
// Description : On a rising edge of done, snapshots the packed results and
//               the clamped result count, then streams a header word (count)
//               followed by every mark of every stored result over a
//               valid/ready link, one 9-bit word per beat.
//               Optional feature macro: MARK_STREAM_CHECKSUM_EN appends a
//               trailer word holding the XOR of all preceding frame words.
// Revision    : 1.0 - initial release
// ============================================================================
module mark_result_streamer
  import mark_pkg::*;
#(
  parameter int NUMPOSITIONS = 5,
  parameter int NUMRESULTS   = 10
) (
  input  logic                                           clock,
  input  logic                                           reset,
  input  logic                                           done,
  input  logic [CNTWIDTH-1:0]                            numResults,
  input  logic [slot_width(NUMPOSITIONS)*NUMRESULTS-1:0] results,
  output logic [MARKWIDTH-1:0]                           out_data,
  output logic                                           out_valid,
  input  logic                                           out_ready,
  output logic                                           out_first,
  output logic                                           out_last,
  output logic                                           busy,
  output logic                                           overrun
);

  localparam int TOTAL = slot_width(NUMPOSITIONS) * NUMRESULTS;
  localparam logic [CNTWIDTH-1:0] LAST_MI = CNTWIDTH'(NUMPOSITIONS);
  localparam logic [CNTWIDTH-1:0] MAX_CNT = CNTWIDTH'(NUMRESULTS);
`ifdef MARK_STREAM_CHECKSUM_EN
  localparam logic CKSUM_EN = 1'b1;
`else
  localparam logic CKSUM_EN = 1'b0;
`endif

  state_t                state_q, state_d;
  logic                  done_q, done_d;
  logic [TOTAL-1:0]      shadow_q, shadow_d;
  logic [CNTWIDTH-1:0]   cnt_q, cnt_d;
  logic [CNTWIDTH-1:0]   ri_q, ri_d;
  logic [CNTWIDTH-1:0]   mi_q, mi_d;
  logic [MARKWIDTH-1:0]  out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_first_q, out_first_d;
  logic                  out_last_q, out_last_d;
  logic                  busy_q, busy_d;
  logic                  overrun_q, overrun_d;
`ifdef MARK_STREAM_CHECKSUM_EN
  logic [MARKWIDTH-1:0]  xor_q, xor_d;
`endif

  logic                  trigger;
  logic                  beat;
  logic                  frame_end;
  logic                  go_idle;
  logic                  cur_is_last;
  logic                  next_is_last;
  logic [CNTWIDTH-1:0]   clamped;
  logic [CNTWIDTH-1:0]   next_ri;
  logic [CNTWIDTH-1:0]   next_mi;
  logic [MARKWIDTH-1:0]  sel_word;

  // The selector always looks one word ahead so the output register is
  // loaded with the following mark on each beat.
  mark_word_select #(
    .NUMPOSITIONS (NUMPOSITIONS),
    .NUMRESULTS   (NUMRESULTS)
  ) u_word_select (
    .vec  (shadow_q),
    .ri   (next_ri),
    .mi   (next_mi),
    .word (sel_word)
  );

  // Next-state and registered-output computation for the frame FSM.
  always_comb begin
    state_d     = state_q;
    done_d      = done;
    shadow_d    = shadow_q;
    cnt_d       = cnt_q;
    ri_d        = ri_q;
    mi_d        = mi_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
`ifdef MARK_STREAM_CHECKSUM_EN
    xor_d       = xor_q;
`endif
    frame_end   = 1'b0;
    go_idle     = 1'b0;

    trigger   = done & ~done_q;
    beat      = out_valid_q & out_ready;
    overrun_d = overrun_q | (trigger & (state_q != ST_IDLE));
    clamped   = (numResults > MAX_CNT) ? MAX_CNT : numResults;

    if (state_q == ST_HEADER) begin
      next_ri = CNTWIDTH'(1);
      next_mi = '0;
    end else if (mi_q == LAST_MI) begin
      next_ri = ri_q + 1'b1;
      next_mi = '0;
    end else begin
      next_ri = ri_q;
      next_mi = mi_q + 1'b1;
    end
    cur_is_last  = (ri_q == cnt_q) && (mi_q == LAST_MI);
    next_is_last = (next_ri == cnt_q) && (next_mi == LAST_MI);

    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          shadow_d    = results;
          cnt_d       = clamped;
          state_d     = ST_HEADER;
          out_data_d  = MARKWIDTH'(clamped);
          out_valid_d = 1'b1;
          out_first_d = 1'b1;
          out_last_d  = ~CKSUM_EN & (clamped == '0);
          busy_d      = 1'b1;
`ifdef MARK_STREAM_CHECKSUM_EN
          xor_d       = MARKWIDTH'(clamped);
`endif
        end
      end
      ST_HEADER, ST_MARKS: begin
        if (beat) begin
          out_first_d = 1'b0;
          if ((state_q == ST_HEADER) ? (cnt_q == '0) : cur_is_last) begin
            frame_end = 1'b1;
          end else begin
            state_d    = ST_MARKS;
            ri_d       = next_ri;
            mi_d       = next_mi;
            out_data_d = sel_word;
            out_last_d = ~CKSUM_EN & next_is_last;
`ifdef MARK_STREAM_CHECKSUM_EN
            xor_d      = xor_q ^ sel_word;
`endif
          end
        end
      end
`ifdef MARK_STREAM_CHECKSUM_EN
      ST_TRAILER: begin
        if (beat) go_idle = 1'b1;
      end
`endif
      default: begin
        go_idle = 1'b1;
      end
    endcase

    if (frame_end) begin
`ifdef MARK_STREAM_CHECKSUM_EN
      state_d     = ST_TRAILER;
      out_data_d  = xor_q;
      out_last_d  = 1'b1;
`else
      go_idle     = 1'b1;
`endif
    end

    if (go_idle) begin
      state_d     = ST_IDLE;
      out_data_d  = '0;
      out_valid_d = 1'b0;
      out_first_d = 1'b0;
      out_last_d  = 1'b0;
      busy_d      = 1'b0;
    end
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      done_q      <= 1'b0;
      shadow_q    <= '0;
      cnt_q       <= '0;
      ri_q        <= '0;
      mi_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef MARK_STREAM_CHECKSUM_EN
      xor_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      shadow_q    <= shadow_d;
      cnt_q       <= cnt_d;
      ri_q        <= ri_d;
      mi_q        <= mi_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
`ifdef MARK_STREAM_CHECKSUM_EN
      xor_q       <= xor_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: doc/mark_result_streamer.md
# mark_result_streamer

Host-side result unloader for the Golomb ruler search. When `mark_counter_assembly` raises `done`, it snapshots the packed `results` vector and `numResults`. It then streams a header word and every mark of every stored solution, one 9-bit word per beat, over a valid/ready interface to the host link. It is the read-out counterpart of the simulation-only result printing, making the searcher usable on a real FPGA.

## Interface
- `NUMPOSITIONS`, 5, marks beyond 0; each result holds NUMPOSITIONS+1 marks
- `NUMRESULTS`, 10, result slots in `results`
- `clock`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low (0 = reset)
- `done`  in  1  search finished, level from assembly
- `numResults`  in  6  valid result count
- `results`  in  (NUMPOSITIONS+1)*9*NUMRESULTS  packed results, indexed [..:1]; r[1] in the MSBs, m[0] in the MSBs of each result
- `out_data`  out  9  stream word
- `out_valid`  out  1  word available
- `out_ready`  in  1  host accepts word
- `out_first`  out  1  marks the header word
- `out_last`  out  1  marks the final word of the frame
- `busy`  out  1  frame in progress
- `overrun`  out  1  sticky: a `done` rising edge arrived while busy

## Operation
- Detect rising edge of `done` via the registered `done_d`. Trigger = `done & ~done_d`.
- States: IDLE, HEADER, MARKS, TRAILER (TRAILER exists only with the macro).
- IDLE + trigger: capture `results` into a shadow register and `cnt = min(numResults, NUMRESULTS)`. Go to HEADER.
- HEADER: `out_data = {3'b0, cnt}`, `out_first=1`. On beat: if cnt==0 go to end-of-frame, else go to MARKS with ri=1, mi=0.
- MARKS: `out_data` = mark mi of result ri from the shadow. On each beat, mi increments. At mi==NUMPOSITIONS, mi wraps to 0 and ri increments. After the beat at (ri==cnt, mi==NUMPOSITIONS), go to end-of-frame.
- End-of-frame: TRAILER if enabled, else IDLE.
- `out_last` is high on exactly one word per frame:
  - the header when cnt==0;
  - otherwise the last mark;
  - the trailer if enabled.
- A beat is `out_valid & out_ready`. While `out_valid & ~out_ready`, `out_data`, `out_first` and `out_last` are held stable.
- Trigger while not IDLE: ignored, `overrun` set. It is cleared only by reset.
- `numResults` > NUMRESULTS: clamped to NUMRESULTS.
- Reset asserted mid-frame: abort immediately to IDLE, and the stream ends without `out_last`.

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `out_first`=0, `out_last`=0, `busy`=0, `overrun`=0. `done_d`=0, shadow=0.
- The trigger seen at clock edge t gives `out_valid`=1 with the header after edge t. First word latency is 1 cycle.
- One word per cycle with `out_ready` held high. Frame length is 1 + cnt*(NUMPOSITIONS+1) words, plus 1 with the checksum.
- `busy` rises together with `out_valid` for the header. It falls on the cycle after the `out_last` beat, together with `out_valid`.
- Output registers only; `out_valid` has no combinational dependence on `out_ready`.
- `done` held high across frames causes no re-trigger. A new frame needs `done` to go low and then high again.

## Configuration
- `MARK_STREAM_CHECKSUM_EN` defined:
  - after the last data word, send one trailer word = XOR of all preceding words in the frame, header included;
  - the trailer carries `out_last`;
  - frame length grows by 1.
- Undefined: no TRAILER state and no XOR accumulator; `out_last` sits on the last data word.

## Structure
- Shared package `mark_pkg`:
  - `MARKWIDTH`=9;
  - state enumeration (IDLE, HEADER, MARKS, TRAILER);
  - the function computing the result-slot width (NUMPOSITIONS+1)*MARKWIDTH;
  - the count width (6).
- Sub-module `mark_word_select`: combinational indexer returning the 9-bit mark (ri, mi) from the shadow vector using the MSB-first packing. It is also reused by the future `firstvalues` loader.

## Test plan
- NUMPOSITIONS=5, one result 0-1-4-10-12-17, numResults=1, `out_ready`=1 → words 1,0,1,4,10,12,17. `out_first` on word 1, `out_last` on 17, 7 consecutive beats, then `busy`=0.
- numResults=0 with `done` rising → single word 0 with `out_first` and `out_last` both high.
- Two results, `out_ready` toggling every other cycle → 13 words in order, held stable during stalls, no loss or duplication.
- numResults=12 (NUMRESULTS=10) → header 10, 61 words total.
- `done` pulsed again mid-frame → frame unaffected, `overrun`=1. Reset (0) during MARKS → all outputs 0 next cycle, `overrun` cleared.
- With `MARK_STREAM_CHECKSUM_EN`, result 0-1-4-10-12-17 → trailer = 1^0^1^4^10^12^17 = 19, carries `out_last`.
